// File: rtl/urna_pkg.sv
// Shared definitions for the multi-candidate ballot box.
package urna_pkg;

  localparam int unsigned MAX_CAND   = 14;
  localparam logic [3:0]  BLANK_CODE = 4'd0;

  typedef enum logic [1:0] {
    FECHADA   = 2'd0,
    AGUARDA   = 2'd1,
    CONFIRMA  = 2'd2,
    ENCERRADA = 2'd3
  } state_t;

endpackage

// File: rtl/urna_contador_sat.sv
// Saturating up-counter; Sat flags an increment request that hit the ceiling.
module urna_contador_sat #(
  parameter int unsigned W = 8
) (
  input  logic         Clock,
  input  logic         ResetN,
  input  logic         Inc,
  output logic [W-1:0] Q,
  output logic         Sat
);

  assign Sat = Inc & (&Q);

  // Count up on Inc, holding once all-ones is reached.
  always_ff @(posedge Clock) begin
    if (!ResetN) Q <= '0;
    else if (Inc && !(&Q)) Q <= Q + 1'b1;
  end

endmodule

// File: rtl/urna_multicanal.sv
// Multi-candidate ballot box: enter/confirm/cancel voting FSM, saturating
// tallies and a sequential winner scan after the election closes.
module urna_multicanal
  import urna_pkg::*;
#(
  parameter int unsigned NUM_CAND = 4,
  parameter int unsigned COUNT_W  = 8,
  parameter int unsigned TOTAL_W  = 12
) (
  input  logic                        Clock,
  input  logic                        ResetN,
  input  logic                        Start,
  input  logic [3:0]                  Digit,
  input  logic                        Valid,
  input  logic                        Confirm,
  input  logic                        Cancel,
  input  logic                        Finish,
  output logic [NUM_CAND*COUNT_W-1:0] Counts,
  output logic [COUNT_W-1:0]          Blank,
  output logic [COUNT_W-1:0]          Nulo,
  output logic [TOTAL_W-1:0]          Total,
  output logic [3:0]                  Pending,
  output logic                        VoteStatus,
  output logic                        Overflow,
  output logic [1:0]                  State,
  output logic                        Done,
  output logic [3:0]                  Winner,
  output logic                        Tie
);

  state_t state_q, state_d;

  logic accept, latch, drop;
  logic [NUM_CAND-1:0] inc_cand, sat_cand;
  logic inc_blank, inc_nulo, sat_blank, sat_nulo, sat_total;
  logic [COUNT_W-1:0] cnt_q [NUM_CAND];

  logic [3:0]         scan_idx, best_idx;
  logic [COUNT_W-1:0] best_val, scan_cnt;
  logic               tie_q, done_q;

  // State register.
  always_ff @(posedge Clock) begin
    if (!ResetN) state_q <= FECHADA;
    else         state_q <= state_d;
  end

  // Next-state logic; Finish outranks Cancel, which outranks Confirm and Valid.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FECHADA:   if (Finish) state_d = ENCERRADA;
                 else if (Start) state_d = AGUARDA;
      AGUARDA:   if (Finish) state_d = ENCERRADA;
                 else if (Valid) state_d = CONFIRMA;
      CONFIRMA:  if (Finish) state_d = ENCERRADA;
                 else if (Cancel || Confirm) state_d = AGUARDA;
      default:   state_d = ENCERRADA;
    endcase
  end

  // Per-state control strobes for the pending register and the tallies.
  always_comb begin
    accept = 1'b0;
    latch  = 1'b0;
    drop   = 1'b0;
    case (state_q)
      AGUARDA:  latch = Valid & ~Finish;
      CONFIRMA: begin
        if (Finish || Cancel) drop = 1'b1;
        else if (Confirm)     accept = 1'b1;
        else if (Valid)       latch = 1'b1;
      end
      default: ;
    endcase
  end

  // Pending code: latched on Valid, cleared once the vote is resolved.
  always_ff @(posedge Clock) begin
    if (!ResetN)              Pending <= '0;
    else if (latch)           Pending <= Digit;
    else if (drop || accept)  Pending <= '0;
  end

  // Classify the committed code into candidate, blank or null.
  always_comb begin
    for (int unsigned k = 0; k < NUM_CAND; k++)
      inc_cand[k] = accept && (Pending == 4'(k + 1));
    inc_blank = accept && (Pending == BLANK_CODE);
    inc_nulo  = accept && (Pending > 4'(NUM_CAND));
  end

  for (genvar k = 0; k < NUM_CAND; k++) begin : g_cand
    urna_contador_sat #(.W(COUNT_W)) u_cnt (
      .Clock(Clock), .ResetN(ResetN), .Inc(inc_cand[k]),
      .Q(cnt_q[k]), .Sat(sat_cand[k])
    );
    assign Counts[k*COUNT_W +: COUNT_W] = cnt_q[k];
  end

  urna_contador_sat #(.W(COUNT_W)) u_blank (
    .Clock(Clock), .ResetN(ResetN), .Inc(inc_blank), .Q(Blank), .Sat(sat_blank)
  );
  urna_contador_sat #(.W(COUNT_W)) u_nulo (
    .Clock(Clock), .ResetN(ResetN), .Inc(inc_nulo), .Q(Nulo), .Sat(sat_nulo)
  );
  urna_contador_sat #(.W(TOTAL_W)) u_total (
    .Clock(Clock), .ResetN(ResetN), .Inc(accept), .Q(Total), .Sat(sat_total)
  );

  // Acceptance pulse and sticky saturation flag.
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      VoteStatus <= 1'b0;
      Overflow   <= 1'b0;
    end else begin
      VoteStatus <= accept;
      if (|sat_cand || sat_blank || sat_nulo || sat_total) Overflow <= 1'b1;
    end
  end

  // Select the tally of the candidate currently under scan.
  always_comb begin
    scan_cnt = '0;
    for (int unsigned k = 0; k < NUM_CAND; k++)
      if (scan_idx == 4'(k)) scan_cnt = cnt_q[k];
  end

  // Winner scan: one candidate per cycle, first maximum wins, ties flagged.
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      scan_idx <= '0;
      best_idx <= '0;
      best_val <= '0;
      tie_q    <= 1'b0;
      done_q   <= 1'b0;
    end else if (state_q == ENCERRADA && !done_q) begin
      if (scan_cnt > best_val) begin
        best_val <= scan_cnt;
        best_idx <= scan_idx;
        tie_q    <= 1'b0;
      end else if (scan_cnt == best_val && best_val != '0) begin
        tie_q <= 1'b1;
      end
      if (scan_idx == 4'(NUM_CAND - 1)) done_q <= 1'b1;
      scan_idx <= scan_idx + 4'd1;
    end
  end

  assign State  = state_q;
  assign Done   = done_q;
  assign Winner = (done_q && best_val != '0) ? best_idx + 4'd1 : '0;
  assign Tie    = done_q & tie_q;

endmodule

// File: tb/tb_urna_multicanal.sv
// Directed bench for urna_multicanal: a default instance plus a COUNT_W=2
// instance sharing the same stimulus for saturation checks.
module tb_urna_multicanal;

  logic       clk = 1'b0;
  logic       rst_n, start, valid, confirm, cancel, finish;
  logic [3:0] digit;

  logic [31:0] counts;
  logic [7:0]  blank, nulo;
  logic [11:0] total;
  logic [3:0]  pending, winner;
  logic        vote_status, overflow, done, tie;
  logic [1:0]  state;

  logic [7:0]  s_counts;
  logic [1:0]  s_blank, s_nulo;
  logic [11:0] s_total;
  logic [3:0]  s_pending, s_winner;
  logic        s_vote_status, s_overflow, s_done, s_tie;
  logic [1:0]  s_state;

  int checks = 0;
  int passed = 0;
  int pulses = 0;

  always #5 clk = ~clk;

  urna_multicanal #(.NUM_CAND(4), .COUNT_W(8), .TOTAL_W(12)) dut (
    .Clock(clk), .ResetN(rst_n), .Start(start), .Digit(digit), .Valid(valid),
    .Confirm(confirm), .Cancel(cancel), .Finish(finish), .Counts(counts),
    .Blank(blank), .Nulo(nulo), .Total(total), .Pending(pending),
    .VoteStatus(vote_status), .Overflow(overflow), .State(state),
    .Done(done), .Winner(winner), .Tie(tie)
  );

  urna_multicanal #(.NUM_CAND(4), .COUNT_W(2), .TOTAL_W(12)) dut_s (
    .Clock(clk), .ResetN(rst_n), .Start(start), .Digit(digit), .Valid(valid),
    .Confirm(confirm), .Cancel(cancel), .Finish(finish), .Counts(s_counts),
    .Blank(s_blank), .Nulo(s_nulo), .Total(s_total), .Pending(s_pending),
    .VoteStatus(s_vote_status), .Overflow(s_overflow), .State(s_state),
    .Done(s_done), .Winner(s_winner), .Tie(s_tie)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; valid = 1'b0; confirm = 1'b0;
    cancel = 1'b0; finish = 1'b0; digit = 4'd0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic open_election();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic vote(input logic [3:0] d);
    valid = 1'b1; digit = d; step(); valid = 1'b0;
    confirm = 1'b1; step(); confirm = 1'b0;
    if (vote_status) pulses++;
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_state", state, 2'd0);
    check("rst_counts", counts, 32'h0);
    check("rst_total", total, 12'd0);
    check("rst_flags", {done, winner, tie, overflow, vote_status, pending}, '0);

    // Basic voting: 1,2,2,0,9
    open_election();
    check("open_state", state, 2'd1);
    valid = 1'b1; digit = 4'd1; step(); valid = 1'b0;
    check("latch_state", state, 2'd2);
    check("latch_pending", pending, 4'd1);
    confirm = 1'b1; step(); confirm = 1'b0;
    if (vote_status) pulses++;
    check("first_total", total, 12'd1);
    vote(4'd2); vote(4'd2); vote(4'd0); vote(4'd9);
    check("counts_basic", counts, 32'h0000_0201);
    check("blank_basic", blank, 8'd1);
    check("nulo_basic", nulo, 8'd1);
    check("total_basic", total, 12'd5);
    check("pulses_basic", pulses, 5);
    step();
    check("vs_one_cycle", vote_status, 1'b0);

    // Digit correction, then cancel beating confirm
    valid = 1'b1; digit = 4'd3; step();
    digit = 4'd4; step(); valid = 1'b0;
    check("corr_pending", pending, 4'd4);
    check("corr_state", state, 2'd2);
    confirm = 1'b1; step(); confirm = 1'b0;
    check("corr_counts", counts, 32'h0100_0201);
    check("corr_total", total, 12'd6);
    valid = 1'b1; digit = 4'd2; step(); valid = 1'b0;
    cancel = 1'b1; confirm = 1'b1; step(); cancel = 1'b0; confirm = 1'b0;
    check("cancel_state", state, 2'd1);
    check("cancel_total", total, 12'd6);
    check("cancel_vs", vote_status, 1'b0);
    check("cancel_pending", pending, 4'd0);

    // Saturation on the narrow instance
    do_reset();
    open_election();
    repeat (4) vote(4'd1);
    check("sat_counts", s_counts, 8'h03);
    check("sat_overflow", s_overflow, 1'b1);
    check("sat_total", s_total, 12'd4);
    check("sat_vs", s_vote_status, 1'b1);
    check("wide_no_overflow", overflow, 1'b0);
    check("wide_counts", counts, 32'h0000_0004);

    // Tie scan: votes 3,3,1,1
    do_reset();
    open_election();
    vote(4'd3); vote(4'd3); vote(4'd1); vote(4'd1);
    finish = 1'b1; step(); finish = 1'b0;
    check("enc_state", state, 2'd3);
    check("enc_before", {done, winner, tie}, '0);
    for (int i = 1; i <= 3; i++) begin
      step();
      check($sformatf("scan_wait%0d", i), {done, winner, tie}, '0);
    end
    step();
    check("scan_done", done, 1'b1);
    check("scan_winner", winner, 4'd1);
    check("scan_tie", tie, 1'b1);
    vote(4'd2);
    check("frozen_total", total, 12'd4);
    check("frozen_counts", counts, 32'h0002_0002);

    // Finish while a vote is pending
    do_reset();
    open_election();
    vote(4'd1);
    valid = 1'b1; digit = 4'd2; step(); valid = 1'b0;
    check("pend_before_fin", pending, 4'd2);
    finish = 1'b1; step(); finish = 1'b0;
    check("fin_state", state, 2'd3);
    check("fin_total", total, 12'd1);
    confirm = 1'b1; step(); confirm = 1'b0;
    check("fin_ignored_total", total, 12'd1);
    check("fin_ignored_vs", vote_status, 1'b0);
    repeat (4) step();
    check("fin_winner", {done, winner, tie}, {1'b1, 4'd1, 1'b0});

    // Empty election straight from FECHADA
    do_reset();
    finish = 1'b1; step(); finish = 1'b0;
    check("empty_state", state, 2'd3);
    repeat (4) step();
    check("empty_result", {done, winner, tie}, {1'b1, 4'd0, 1'b0});

    // Reset during the scan
    do_reset();
    open_election();
    vote(4'd2);
    finish = 1'b1; step(); finish = 1'b0;
    step(); step();
    rst_n = 1'b0; step();
    check("midrst_state", state, 2'd0);
    check("midrst_outs", {counts, total, done, winner, tie, pending, vote_status, overflow}, '0);
    rst_n = 1'b1; step();
    check("midrst_hold", {state, done, total}, '0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
